lives_heart_renderer: RTL and testbench

- Reader side of the heart sprite BRAM. Draws the player's remaining lives as a row of 16x16 hearts over the background pixel stream.
- Generates sprite_x/sprite_y from the VGA counters and absorbs the BRAM's one-cycle read latency.
- Owns the lives counter, the game-over flag and the blink animation of a just-lost heart.
- Sits between the VGA timing generator and the final colour mux.

---
 rtl/lives_heart_renderer.sv | 182 ++++++++++++++++++
 tb/tb_lives_heart_renderer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lives_heart_renderer.sv
// Lives HUD: draws a row of heart sprites over the background stream, owns the lives
// counter and blinks the most recently lost heart.
module lives_heart_renderer #(
  parameter int MAX_LIVES     = 3,
  parameter int HEART_X0      = 8,
  parameter int HEART_Y0      = 8,
  parameter int HEART_SPACING = 20,
  parameter int BLINK_FRAMES  = 8,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic       frame_start,
  input  logic       life_lost,
  input  logic       game_restart,
  input  logic [5:0] bg_pixel,
  output logic [3:0] sprite_x,
  output logic [3:0] sprite_y,
  input  logic [5:0] sprite_pixel,
  output logic [5:0] pixel_out,
  output logic [2:0] lives,
  output logic       game_over
);

  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam int TW = $clog2(BLINK_TOGGLES + 1);

  typedef enum logic {IDLE, BLINK} state_t;

  state_t        state_q, state_d;
  logic [2:0]    lives_q, lives_d;
  logic          game_over_q, game_over_d;
  logic          blink_on_q, blink_on_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [TW-1:0] toggle_cnt_q, toggle_cnt_d;

  logic [2:0]    lives_disp_q;
  logic          blink_disp_q;

  logic [3:0]    sprite_x_q, sprite_y_q;
  logic          draw1_q, draw2_q;
  logic [5:0]    bg1_q, bg2_q;
  logic [5:0]    pixel_out_q;

  logic          in_region;
  logic [2:0]    slot_idx;
  logic [3:0]    slot_off;
  logic [3:0]    row_off;
  logic          v_in;
  logic          draw_c;

  function automatic logic [10:0] slot_base(input int i);
    return 11'(HEART_X0 + i * HEART_SPACING);
  endfunction

  assign v_in    = (v_count >= 10'(HEART_Y0)) && (v_count < 10'(HEART_Y0 + 16));
  assign row_off = 4'(v_count - 10'(HEART_Y0));

  // Slots never overlap (pitch >= 16), so at most one slot matches.
  always_comb begin
    in_region = 1'b0;
    slot_idx  = 3'd0;
    slot_off  = 4'd0;
    for (int i = 0; i < MAX_LIVES; i++) begin
      if (v_in && ({1'b0, h_count} >= slot_base(i)) &&
          ({1'b0, h_count} < slot_base(i) + 11'd16)) begin
        in_region = 1'b1;
        slot_idx  = 3'(i);
        slot_off  = 4'({1'b0, h_count} - slot_base(i));
      end
    end
  end

  assign draw_c = in_region &&
                  ((slot_idx < lives_disp_q) || ((slot_idx == lives_disp_q) && blink_disp_q));

  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    blink_on_d   = blink_on_q;
    frame_cnt_d  = frame_cnt_q;
    toggle_cnt_d = toggle_cnt_q;
    if (game_restart) begin
      state_d      = IDLE;
      lives_d      = 3'(MAX_LIVES);
      blink_on_d   = 1'b0;
      frame_cnt_d  = '0;
      toggle_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (life_lost && (lives_q != 3'd0)) begin
            lives_d      = lives_q - 3'd1;
            state_d      = BLINK;
            blink_on_d   = 1'b1;
            frame_cnt_d  = '0;
            toggle_cnt_d = '0;
          end
        end
        BLINK: begin
          if (frame_start) begin
            if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
              frame_cnt_d = '0;
              if (toggle_cnt_q == TW'(BLINK_TOGGLES - 1)) begin
                state_d      = IDLE;
                blink_on_d   = 1'b0;
                toggle_cnt_d = '0;
              end else begin
                blink_on_d   = ~blink_on_q;
                toggle_cnt_d = toggle_cnt_q + TW'(1);
              end
            end else begin
              frame_cnt_d = frame_cnt_q + FW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    game_over_d = (lives_d == 3'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lives_q      <= 3'(MAX_LIVES);
      game_over_q  <= 1'b0;
      blink_on_q   <= 1'b0;
      frame_cnt_q  <= '0;
      toggle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      game_over_q  <= game_over_d;
      blink_on_q   <= blink_on_d;
      frame_cnt_q  <= frame_cnt_d;
      toggle_cnt_q <= toggle_cnt_d;
    end
  end

  // Display state only moves at frame boundaries so a heart never tears mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      lives_disp_q <= 3'(MAX_LIVES);
      blink_disp_q <= 1'b0;
    end else if (frame_start) begin
      lives_disp_q <= lives_q;
      blink_disp_q <= blink_on_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sprite_x_q  <= 4'd0;
      sprite_y_q  <= 4'd0;
      draw1_q     <= 1'b0;
      draw2_q     <= 1'b0;
      bg1_q       <= 6'd0;
      bg2_q       <= 6'd0;
      pixel_out_q <= 6'd0;
    end else begin
      if (in_region) begin
        sprite_x_q <= slot_off;
        sprite_y_q <= row_off;
      end
      draw1_q     <= draw_c;
      bg1_q       <= bg_pixel;
      draw2_q     <= draw1_q;
      bg2_q       <= bg1_q;
      pixel_out_q <= (draw2_q && (sprite_pixel != 6'd0)) ? sprite_pixel : bg2_q;
    end
  end

  assign sprite_x  = sprite_x_q;
  assign sprite_y  = sprite_y_q;
  assign pixel_out = pixel_out_q;
  assign lives     = lives_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_lives_heart_renderer.sv
// Bench for lives_heart_renderer: directed vector table, blink/lives sequences and
// random stimulus, all checked against a frame-level reference model.
module tb_lives_heart_renderer;

  localparam int MAXL = 3;
  localparam int X0   = 8;
  localparam int Y0   = 8;
  localparam int SPC  = 20;
  localparam int BF   = 8;
  localparam int BT   = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] h_count, v_count;
  logic       frame_start, life_lost, game_restart;
  logic [5:0] bg_pixel, sprite_pixel;
  logic [3:0] sprite_x, sprite_y;
  logic [5:0] pixel_out;
  logic [2:0] lives;
  logic       game_over;

  always #5 clk = ~clk;

  lives_heart_renderer #(
    .MAX_LIVES(MAXL), .HEART_X0(X0), .HEART_Y0(Y0), .HEART_SPACING(SPC),
    .BLINK_FRAMES(BF), .BLINK_TOGGLES(BT)
  ) dut (
    .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count),
    .frame_start(frame_start), .life_lost(life_lost), .game_restart(game_restart),
    .bg_pixel(bg_pixel), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_pixel(sprite_pixel), .pixel_out(pixel_out), .lives(lives), .game_over(game_over)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: lives plus "frames elapsed since the hit" for the blink.
  int m_lives, m_fs, m_disp_lives, m_sx, m_sy, m_pix;
  bit m_blinking, m_disp_blink;
  bit p1_draw, p2_draw;
  int p1_bg, p2_bg;

  typedef struct {
    int h; int v; int bg; int sp; int sx; int sy; int pix;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int slot_of(input int h, input int v);
    if (v < Y0 || v >= Y0 + 16) return -1;
    for (int i = 0; i < MAXL; i++)
      if (h >= X0 + i * SPC && h < X0 + i * SPC + 16) return i;
    return -1;
  endfunction

  function automatic bit blink_visible();
    return m_blinking && (((m_fs / BF) % 2) == 0);
  endfunction

  task automatic model_reset();
    m_lives = MAXL; m_fs = 0; m_blinking = 0;
    m_disp_lives = MAXL; m_disp_blink = 0;
    m_sx = 0; m_sy = 0; m_pix = 0;
    p1_draw = 0; p2_draw = 0; p1_bg = 0; p2_bg = 0;
  endtask

  task automatic step(input int h, input int v, input int bg, input int sp,
                      input bit fs, input bit ll, input bit gr, input bit r);
    int s;
    bit d;
    bit vis;
    @(negedge clk);
    h_count = 10'(h); v_count = 10'(v); bg_pixel = 6'(bg); sprite_pixel = 6'(sp);
    frame_start = fs; life_lost = ll; game_restart = gr; rst = r;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      s = slot_of(h, v);
      d = (s >= 0) && ((s < m_disp_lives) || (s == m_disp_lives && m_disp_blink));
      if (s >= 0) begin
        m_sx = h - (X0 + s * SPC);
        m_sy = v - Y0;
      end
      m_pix = (p2_draw && sp != 0) ? sp : p2_bg;
      p2_draw = p1_draw; p2_bg = p1_bg;
      p1_draw = d;       p1_bg = bg;
      vis = blink_visible();
      if (fs) begin
        m_disp_lives = m_lives;
        m_disp_blink = vis;
      end
      if (gr) begin
        m_lives = MAXL; m_blinking = 0; m_fs = 0;
      end else if (ll && !m_blinking && m_lives > 0) begin
        m_lives--; m_blinking = 1; m_fs = 0;
      end else if (m_blinking && fs) begin
        m_fs++;
        if (m_fs == BF * BT) begin
          m_blinking = 0; m_fs = 0;
        end
      end
    end
    #1;
    check("sprite_x", sprite_x, m_sx);
    check("sprite_y", sprite_y, m_sy);
    check("pixel_out", pixel_out, m_pix);
    check("lives", lives, m_lives);
    check("game_over", game_over, (m_lives == 0) ? 1 : 0);
  endtask

  task automatic idle(input int sp);
    step(700, 500, 0, sp, 0, 0, 0, 0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(700, 500, 0, 0, 1, 0, 0, 0);
      idle(0);
    end
  endtask

  // One frame: pulse frame_start, then render one pixel of slot 2.
  task automatic probe_slot2(input int frame_no, input bit exp_drawn);
    step(700, 500, 0, 0, 1, 0, 0, 0);
    step(50, 10, 1, 0, 0, 0, 0, 0);
    idle(0);
    idle(42);
    check($sformatf("blink_f%0d", frame_no), pixel_out, exp_drawn ? 42 : 1);
  endtask

  initial begin
    tbl[0]  = '{10, 10, 12, 32,  2,  2, 32};
    tbl[1]  = '{10, 10, 12,  0,  2,  2, 12};
    tbl[2]  = '{ 8,  8, 21, 63,  0,  0, 63};
    tbl[3]  = '{23, 23,  1,  7, 15, 15,  7};
    tbl[4]  = '{24, 10, 17, 34, 15, 15, 17};
    tbl[5]  = '{28, 12,  2, 48,  0,  4, 48};
    tbl[6]  = '{63, 23,  3,  5, 15, 15,  5};
    tbl[7]  = '{64, 10, 42,  9, 15, 15, 42};
    tbl[8]  = '{68, 10,  3,  9, 15, 15,  3};
    tbl[9]  = '{10, 24,  4,  9, 15, 15,  4};
    tbl[10] = '{10,  7,  5,  9, 15, 15,  5};

    model_reset();
    h_count = '0; v_count = '0; bg_pixel = '0; sprite_pixel = '0;
    frame_start = 0; life_lost = 0; game_restart = 0; rst = 1;

    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("reset_lives", lives, 3);
    check("reset_game_over", game_over, 0);
    check("reset_pixel_out", pixel_out, 0);
    check("reset_sprite_x", sprite_x, 0);

    foreach (tbl[k]) begin
      step(tbl[k].h, tbl[k].v, tbl[k].bg, 0, 0, 0, 0, 0);
      check($sformatf("tbl%0d_sx", k), sprite_x, tbl[k].sx);
      check($sformatf("tbl%0d_sy", k), sprite_y, tbl[k].sy);
      idle(0);
      idle(tbl[k].sp);
      check($sformatf("tbl%0d_pix", k), pixel_out, tbl[k].pix);
    end

    // Partial frame scan covering all three slots and their borders.
    step(700, 500, 0, 0, 1, 0, 0, 0);
    for (int v = 0; v < 32; v++)
      for (int h = 0; h < 80; h++)
        step(h, v, $urandom_range(0, 63),
             ($urandom % 4 == 0) ? 0 : $urandom_range(1, 63), 0, 0, 0, 0);

    // Single hit: slot 2 blinks 8 frames on / 8 off, gone after 48 frames.
    step(700, 500, 0, 0, 0, 1, 0, 0);
    check("hit1_lives", lives, 2);
    for (int f = 1; f <= 52; f++) begin
      if (f == 20) begin
        step(700, 500, 0, 0, 0, 1, 0, 0);
        check("invuln_lives", lives, 2);
      end
      probe_slot2(f, (f <= 48) && ((((f - 1) / BF) % 2) == 0));
    end
    step(700, 500, 0, 0, 0, 1, 0, 0);
    check("idle_after_blink_lives", lives, 1);

    // Restart then hits spaced beyond the blink window.
    step(700, 500, 0, 0, 0, 0, 1, 0);
    check("restart_lives", lives, 3);
    for (int k = 1; k <= 4; k++) begin
      step(700, 500, 0, 0, 0, 1, 0, 0);
      check($sformatf("hit%0d_lives", k), lives, (k >= 3) ? 0 : 3 - k);
      check($sformatf("hit%0d_game_over", k), game_over, (k >= 3) ? 1 : 0);
      frames(50);
    end

    // Restart wins over a same-cycle hit.
    step(700, 500, 0, 0, 0, 0, 1, 0);
    step(700, 500, 0, 0, 0, 1, 0, 0);
    frames(50);
    step(700, 500, 0, 0, 0, 1, 0, 0);
    check("pre_restart_lives", lives, 1);
    step(700, 500, 0, 0, 0, 1, 1, 0);
    check("restart_hit_lives", lives, 3);
    check("restart_hit_game_over", game_over, 0);
    step(700, 500, 0, 0, 0, 1, 0, 0);
    check("restart_then_idle_lives", lives, 2);

    // Reset mid-blink while rendering inside slot 1.
    frames(3);
    step(30, 10, 5, 0, 0, 0, 0, 0);
    step(30, 10, 5, 9, 0, 0, 0, 1);
    check("rst_mid_lives", lives, 3);
    check("rst_mid_pixel", pixel_out, 0);
    for (int i = 0; i < 4; i++)
      step(30, 10, 5, $urandom_range(0, 63), 0, 0, 0, 0);
    step(30, 10, 5, 0, 0, 1, 0, 0);
    idle(0);
    idle(0);
    check("rst_mid_blink_gone", lives, 2);

    // Random traffic.
    for (int i = 0; i < 6000; i++)
      step($urandom_range(0, 79), $urandom_range(0, 31), $urandom_range(0, 63),
           ($urandom % 3 == 0) ? 0 : $urandom_range(1, 63),
           ($urandom % 10 == 0), ($urandom % 150 == 0), ($urandom % 2500 == 0),
           ($urandom % 4000 == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
